// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan driver: blank code, segment
// patterns (gfedcba, active low) and an index-width helper.
package sseg_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hA;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    localparam logic [6:0] SEG_DIGITS [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sseg_decode.sv
// BCD nibble to active-low segment pattern {dp,g,f,e,d,c,b,a}; a blanked
// digit or any code above 9 turns every segment, including dp, off.
module sseg_decode
    import sseg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = {1'b1, SEG_BLANK};
        if (!blank_i && (nibble_i <= 4'd9)) begin
            seg_o = {~dp_i, SEG_DIGITS[nibble_i]};
        end
    end

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed N-digit common-anode display driver with tear-free frame
// updates, leading-zero suppression, per-digit blink and anode guard interval.
module sseg_scan_mux
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD        = 16,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    lz_en,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    output logic [7:0]              sseg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IW = idx_width(NUM_DIGITS);
    localparam int CW = idx_width(SCAN_DIV);
    localparam int BW = idx_width(BLINK_FRAMES);

    logic [CW-1:0]             slot_q;
    logic [IW-1:0]             idx_q;
    logic [4*NUM_DIGITS-1:0]   pend_dig_q, act_dig_q;
    logic [NUM_DIGITS-1:0]     pend_dp_q, act_dp_q;
    logic                      lz_q;
    logic [NUM_DIGITS-1:0]     blink_en_q;
    logic                      hidden_q;
    logic [BW-1:0]             bcnt_q;
    logic [7:0]                sseg_q, sseg_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d;
    logic                      fd_q;

    logic                      slot_end, frame_end;
    logic                      lead;
    logic [NUM_DIGITS-1:0]     suppress;
    logic [3:0]                sel_nib;
    logic                      sel_dp, sel_blank;
    logic [7:0]                seg_dec;

    assign slot_end  = (slot_q == CW'(SCAN_DIV - 1));
    assign frame_end = slot_end && (idx_q == IW'(NUM_DIGITS - 1));

    // Blank codes count as zero so a blank high digit never stops suppression.
    always_comb begin
        lead     = 1'b1;
        suppress = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if ((act_dig_q[4*i +: 4] != 4'd0) && (act_dig_q[4*i +: 4] <= 4'd9)) begin
                lead = 1'b0;
            end
            suppress[i] = lead;
        end
    end

    assign sel_nib   = act_dig_q[{idx_q, 2'b00} +: 4];
    assign sel_dp    = act_dp_q[idx_q];
    assign sel_blank = (lz_q && suppress[idx_q]) || (hidden_q && blink_en_q[idx_q]);

    sseg_decode u_decode (
        .nibble_i (sel_nib),
        .dp_i     (sel_dp),
        .blank_i  (sel_blank),
        .seg_o    (seg_dec)
    );

    always_comb begin
        an_d   = '1;
        sseg_d = 8'hFF;
        if (slot_q >= CW'(GUARD)) begin
            an_d   = ~(NUM_DIGITS'(1) << idx_q);
            sseg_d = seg_dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q     <= '0;
            idx_q      <= '0;
            pend_dig_q <= {NUM_DIGITS{BLANK_CODE}};
            act_dig_q  <= {NUM_DIGITS{BLANK_CODE}};
            pend_dp_q  <= '0;
            act_dp_q   <= '0;
            lz_q       <= 1'b0;
            blink_en_q <= '0;
            hidden_q   <= 1'b0;
            bcnt_q     <= '0;
            sseg_q     <= 8'hFF;
            an_q       <= '1;
            fd_q       <= 1'b0;
        end else begin
            sseg_q <= sseg_d;
            an_q   <= an_d;
            fd_q   <= frame_end;

            if (slot_end) begin
                slot_q     <= '0;
                idx_q      <= (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
                lz_q       <= lz_en;
                blink_en_q <= blink_en;
            end else begin
                slot_q <= slot_q + CW'(1);
            end

            if (load) begin
                pend_dig_q <= digits_in;
                pend_dp_q  <= dp_in;
            end

            // A load landing on the boundary cycle bypasses pending.
            if (frame_end) begin
                act_dig_q <= load ? digits_in : pend_dig_q;
                act_dp_q  <= load ? dp_in : pend_dp_q;
                if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
                    bcnt_q   <= '0;
                    hidden_q <= ~hidden_q;
                end else begin
                    bcnt_q <= bcnt_q + BW'(1);
                end
            end
        end
    end

    assign sseg       = sseg_q;
    assign an         = an_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Self-checking bench for sseg_scan_mux: table of per-frame vectors plus
// reset, tear-free update and blink sequences, checked every cycle.
module tb_sseg_scan_mux;

    localparam int ND = 4;
    localparam int SD = 8;
    localparam int GD = 2;
    localparam int BF = 2;
    localparam int FRAME = ND * SD;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   digits_in;
    logic [3:0]    dp_in;
    logic          load;
    logic          lz_en;
    logic [3:0]    blink_en;
    logic [7:0]    sseg;
    logic [3:0]    an;
    logic          frame_done;

    always #5 clk = ~clk;

    sseg_scan_mux #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .GUARD        (GD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .load       (load),
        .lz_en      (lz_en),
        .blink_en   (blink_en),
        .sseg       (sseg),
        .an         (an),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] sseg;
        logic       fd;
    } exp_t;

    // seg holds the expected pattern per digit: {digit3, digit2, digit1, digit0}
    typedef struct packed {
        logic [15:0] dig;
        logic [3:0]  dp;
        logic        lz;
        logic [31:0] seg;
    } vec_t;

    exp_t sb[$];
    vec_t vec[8];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    function automatic exp_t mk(input logic [3:0] a, input logic [7:0] s, input logic f);
        exp_t e;
        e.an   = a;
        e.sseg = s;
        e.fd   = f;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input exp_t e);
        n_checks++;
        if ({an, sseg, frame_done} !== {e.an, e.sseg, e.fd}) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got an=%h sseg=%h fd=%b, want an=%h sseg=%h fd=%b",
                     name, cyc, an, sseg, frame_done, e.an, e.sseg, e.fd);
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        load  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // Checks one full frame starting at a frame boundary; optionally pulses
    // load at frame cycle load_at with the given next-frame settings.
    task automatic check_frame(input string tag, input logic [31:0] seg, input int load_at,
                               input logic [15:0] ldig, input logic [3:0] ldp,
                               input logic llz, input logic [3:0] lblink);
        logic [3:0] one;
        exp_t       e;
        one = 4'b0001;
        for (int s = 0; s < ND; s++) begin
            for (int c = 0; c < SD; c++) begin
                if (c < GD) e = mk(4'hF, 8'hFF, 1'b0);
                else        e = mk(~(one << s), seg[8*s +: 8], (s == ND - 1) && (c == SD - 1));
                sb.push_back(e);
            end
        end
        for (int i = 0; i < FRAME; i++) begin
            if (i == load_at) begin
                digits_in = ldig;
                dp_in     = ldp;
                lz_en     = llz;
                blink_en  = lblink;
                load      = 1'b1;
            end
            step();
            load = 1'b0;
            e = sb.pop_front();
            chk(tag, e);
        end
    endtask

    initial begin
        digits_in = '0;
        dp_in     = '0;
        load      = 1'b0;
        lz_en     = 1'b0;
        blink_en  = '0;

        vec[0] = '{16'h1234, 4'b0000, 1'b0, 32'hF9A4B099};
        vec[1] = '{16'h1234, 4'b1010, 1'b0, 32'h79A43099};
        vec[2] = '{16'h0070, 4'b0000, 1'b1, 32'hFFFFF8C0};
        vec[3] = '{16'h0000, 4'b0000, 1'b1, 32'hFFFFFFC0};
        vec[4] = '{16'hFA0B, 4'b0000, 1'b0, 32'hFFFFC0FF};
        vec[5] = '{16'h0A05, 4'b0100, 1'b1, 32'hFFFFFF92};
        vec[6] = '{16'h1000, 4'b0000, 1'b1, 32'hF9C0C0C0};
        vec[7] = '{16'h0070, 4'b0000, 1'b0, 32'hC0C0F8C0};

        // Asynchronous reset mid-scan, then restart at digit 0.
        reset_dut();
        repeat (13) step();
        chk("pre_reset", mk(4'hD, 8'hFF, 1'b0));
        #2 rst_n = 1'b0;
        #1 chk("async_reset", mk(4'hF, 8'hFF, 1'b0));
        step();
        chk("held_reset", mk(4'hF, 8'hFF, 1'b0));
        rst_n = 1'b1;
        cyc   = 0;
        step();
        chk("release_c1", mk(4'hF, 8'hFF, 1'b0));
        step();
        chk("release_c2", mk(4'hF, 8'hFF, 1'b0));
        step();
        chk("release_c3", mk(4'hE, 8'hFF, 1'b0));

        // Table vectors, each loaded on the boundary cycle of the prior frame.
        reset_dut();
        check_frame("blank_f0", 32'hFFFFFFFF, FRAME - 1, vec[0].dig, vec[0].dp, vec[0].lz, 4'h0);
        for (int v = 0; v < 8; v++) begin
            if (v < 7)
                check_frame($sformatf("vec%0d", v), vec[v].seg, FRAME - 1,
                            vec[v+1].dig, vec[v+1].dp, vec[v+1].lz, 4'h0);
            else
                check_frame($sformatf("vec%0d", v), vec[v].seg, FRAME - 1,
                            16'h1234, 4'h0, 1'b0, 4'h0);
        end

        // Mid-frame load must not tear the current frame.
        check_frame("tear_old", 32'hF9A4B099, 10, 16'h5678, 4'h0, 1'b0, 4'h0);
        check_frame("tear_new", 32'h9282F880, -1, 16'h0, 4'h0, 1'b0, 4'h0);

        // Blink: two frames visible, two hidden, counted from reset.
        blink_en = 4'b0001;
        reset_dut();
        check_frame("blink_f0", 32'hFFFFFFFF, FRAME - 1, 16'h0009, 4'b0001, 1'b0, 4'b0001);
        for (int f = 1; f < 8; f++) begin
            if (((f / 2) % 2) == 1)
                check_frame($sformatf("blink_hid_f%0d", f), 32'hC0C0C0FF, -1, 16'h0009, 4'b0001, 1'b0, 4'b0001);
            else
                check_frame($sformatf("blink_vis_f%0d", f), 32'hC0C0C010, -1, 16'h0009, 4'b0001, 1'b0, 4'b0001);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sseg_scan_mux.md
Name: sseg_scan_mux

Overview:
Time-multiplexed driver for an N-digit common-anode seven-segment display, used for the traffic-light countdown and density readouts. Latches BCD digit values on a strobe and applies them only at frame boundaries, so the display never tears. Scans one digit per slot and decodes each digit to segment patterns. Adds leading-zero suppression, per-digit blink, decimal points and an anti-ghosting guard interval.

Parameters:
NUM_DIGITS, 4, number of digits/anodes (2..8)
SCAN_DIV, 50000, clk cycles per digit slot (>= GUARD+2)
GUARD, 16, cycles at slot start with all anodes off (anti-ghosting)
BLINK_FRAMES, 250, full scan frames per blink half-period (>= 1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
digits_in  in  4*NUM_DIGITS  BCD digits, nibble i = digit i, digit 0 = least significant
dp_in  in  NUM_DIGITS  decimal point enable per digit
load  in  1  single-cycle strobe; captures digits_in/dp_in into pending registers
lz_en  in  1  leading-zero suppression enable
blink_en  in  NUM_DIGITS  per-digit blink enable
sseg  out  8  segments {dp,g,f,e,d,c,b,a}, active low, registered
an  out  NUM_DIGITS  anode selects, active low, one-hot-cold, registered
frame_done  out  1  one-cycle pulse on the last cycle of the slot for digit NUM_DIGITS-1

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: sseg=8'hFF; an=all ones; frame_done=0; slot counter=0; digit index=0; pending and active digits=4'hA (blank code); pending and active dp=0; blink phase=visible; blink frame counter=0.
- Slot counter counts 0..SCAN_DIV-1 and then wraps. On wrap, the digit index advances 0,1,..,NUM_DIGITS-1,0.
- Frame boundary: the cycle in which both slot counter and digit index wrap to 0. At this boundary, pending is copied to active.
- load captures into pending on any cycle. A load in the boundary cycle forwards the new values straight to active that cycle.
- A load mid-frame is not visible until the next frame.
- Decode per active nibble (segment pattern gfedcba, active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10..15 = blank (1111111)
- dp bit = ~dp for the digit; dp is forced to 1 when the digit is blanked.
- Leading-zero suppression (lz_en=1): scan from digit NUM_DIGITS-1 downward. Digits equal to 0 are blanked until the first nonzero digit. Digit 0 is never suppressed. Blank codes (10..15) count as zero for this scan.
- Blink: the blink frame counter increments per frame. After BLINK_FRAMES frames the phase toggles and the counter clears. In the hidden phase, digits with blink_en set are blanked, dp included.
- Within each slot:
  - Cycles 0..GUARD-1: an=all ones, sseg=8'hFF.
  - Cycles GUARD..SCAN_DIV-1: an bit[index]=0, all other bits 1; sseg = decoded pattern.
- Outputs are registered and lag internal counter state by exactly 1 cycle.
- frame_done is registered and aligned with the output lag.
- Changes to lz_en, blink_en and blink phase take effect at the next slot's first cycle. They do not change mid-slot.
- Reset asserted mid-frame returns all outputs to reset values immediately (asynchronously). Scanning restarts at digit 0 after release.

Decomposition:
- Package sseg_pkg:
  - BLANK_CODE=4'hA
  - SEG_BLANK=7'h7F
  - localparam array of the ten digit patterns
  - function clog2-based index width helper
- Sub-module sseg_decode: a combinational nibble+dp+blank -> 8-bit pattern decoder, instantiated once on the selected digit.

Test Plan:
(All with NUM_DIGITS=4, SCAN_DIV=8, GUARD=2, BLINK_FRAMES=2)
- Reset check: hold rst_n=0 mid-scan -> sseg=8'hFF, an=4'hF immediately. After release, the first enabled slot is digit 0 with an=4'hE at cycle 3 after release.
- Basic scan: load digits=16'h1234, dp=0 before a boundary -> per slot, an=E/D/B/7 with sseg=0x99/0xB0/0xA4/0xF9 (digit0=4, digit1=3, digit2=2, digit3=1). Guard cycles show 0xFF/F. frame_done pulses every 32 cycles.
- Tear-free update: load 16'h5678 at cycle 10 of a frame -> the current frame still shows 1234 and the next frame shows 5678. Load exactly on the boundary cycle -> the new value shows in that frame.
- Leading zeros: digits=16'h0070, lz_en=1 -> digits 3,2 blank (0xFF) and digit1=0xF8, digit0=0xC0. With digits=16'h0000 -> only digit0 shows 0xC0.
- Blink plus dp: blink_en=4'b0001, dp_in=4'b0001, digits=16'h0009 -> digit0 shows 0x10 for 2 frames, then 0xFF for 2 frames, repeating. Other digits are unaffected.
- Blank codes: digits=16'hFA0B, lz_en=0 -> digits 3,2,0 show 0xFF and digit1 shows 0xC0.
